// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-ported data memory between the instruction fetch unit
// (IFU, word reads only) and the load/store unit (LSU, byte/half/word reads
// and writes). Only one transaction is in flight at a time:
//
//   IDLE -> ACCESS (strobe) -> CAPTURE (register read data) -> RESP -> IDLE
//
// A request handshake in cycle T gives resp_valid in cycle T+3.
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN  defined   : on a simultaneous request, the requester
//                                   that did not win last time is granted
//                                   (the last-owner flag resets to IFU).
//                       undefined : fixed priority, the LSU always wins.
//
// Access-size encoding (overridable by predefining the macros):
//   `Mem_Bit = 2'b00, `Mem_Half = 2'b01, `Mem_UHalf = 2'b10, `Mem_Word = 2'b11
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   ifu_req_valid/ready, ifu_addr    IFU request handshake
//   ifu_resp_valid/ready, ifu_rdata  IFU response handshake
//   lsu_req_valid/ready, lsu_addr,
//   lsu_wen, lsu_wdata, lsu_len      LSU request handshake
//   lsu_resp_valid/ready, lsu_rdata  LSU response (rdata = 0 for stores)
//   mem_read, mem_write, mem_addr,
//   mem_wdata, mem_len               memory strobes, driven only in ACCESS
//   mem_rdata                        memory data, valid the cycle after a read
// ---------------------------------------------------------------------------

`ifndef Mem_Bit
`define Mem_Bit 2'b00
`endif
`ifndef Mem_Half
`define Mem_Half 2'b01
`endif
`ifndef Mem_UHalf
`define Mem_UHalf 2'b10
`endif
`ifndef Mem_Word
`define Mem_Word 2'b11
`endif

module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    // IFU
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    input  logic              ifu_resp_ready,
    output logic [DATA_W-1:0] ifu_rdata,
    // LSU
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [1:0]        lsu_len,
    output logic              lsu_resp_valid,
    input  logic              lsu_resp_ready,
    output logic [DATA_W-1:0] lsu_rdata,
    // Memory
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_len,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] MEM_HALF  = `Mem_Half;
    localparam logic [1:0] MEM_UHALF = `Mem_UHalf;
    localparam logic [1:0] MEM_WORD  = `Mem_Word;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_CAPTURE,
        S_RESP
    } state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    state_e              state_q,     state_d;
    owner_e              owner_q,     owner_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic                wen_q,       wen_d;
    logic [DATA_W-1:0]   wdata_q,     wdata_d;
    logic [1:0]          len_q,       len_d;
    logic [DATA_W-1:0]   resp_data_q, resp_data_d;

    logic prefer_lsu;
    logic grant_lsu;
    logic grant_ifu;
    logic owner_resp_ready;

`ifdef ARB_ROUND_ROBIN_EN
    owner_e last_owner_q, last_owner_d;

    // A tie goes to whoever did not win the previous grant.
    assign prefer_lsu = (last_owner_q == OWN_IFU);
`else
    assign prefer_lsu = 1'b1;
`endif

    // Grant is combinational in IDLE. rst_n is folded in because IDLE is also
    // the reset state, and no requester may see ready while reset is held.
    assign grant_lsu = rst_n && (state_q == S_IDLE) && lsu_req_valid
                       && (!ifu_req_valid || prefer_lsu);
    assign grant_ifu = rst_n && (state_q == S_IDLE) && ifu_req_valid && !grant_lsu;

    assign owner_resp_ready = (owner_q == OWN_LSU) ? lsu_resp_ready : ifu_resp_ready;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case statement leaves it unassigned (which would infer a latch).
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        wdata_d     = wdata_q;
        len_d       = len_q;
        resp_data_d = resp_data_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_owner_d = last_owner_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (grant_lsu) begin
                    owner_d = OWN_LSU;
                    addr_d  = lsu_addr;
                    wen_d   = lsu_wen;
                    wdata_d = lsu_wdata;
                    // The memory has no unsigned-half store; the extension
                    // distinction only matters for loads.
                    len_d   = (lsu_wen && lsu_len == MEM_UHALF) ? MEM_HALF : lsu_len;
                    state_d = S_ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
                    last_owner_d = OWN_LSU;
`endif
                end else if (grant_ifu) begin
                    owner_d = OWN_IFU;
                    addr_d  = ifu_addr;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    len_d   = MEM_WORD;
                    state_d = S_ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
                    last_owner_d = OWN_IFU;
`endif
                end
            end

            S_ACCESS: begin
                state_d = S_CAPTURE;
            end

            S_CAPTURE: begin
                // mem_rdata belongs to the strobe of the previous cycle.
                resp_data_d = wen_q ? '0 : mem_rdata;
                state_d     = S_RESP;
            end

            S_RESP: begin
                if (owner_resp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_IFU;
            // NOTE: the latched request and response registers are reset as
            // well; they are a handful of flops and keep every output
            // deterministic straight out of reset.
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            len_q       <= '0;
            resp_data_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_q <= OWN_IFU;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            len_q       <= len_d;
            resp_data_q <= resp_data_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign ifu_req_ready = grant_ifu;
    assign lsu_req_ready = grant_lsu;

    // Strobes, address and data exist only in ACCESS; zero elsewhere so reset
    // and idle cycles present a quiet bus.
    assign mem_read  = (state_q == S_ACCESS) && !wen_q;
    assign mem_write = (state_q == S_ACCESS) &&  wen_q;
    assign mem_addr  = (state_q == S_ACCESS) ? addr_q  : '0;
    assign mem_wdata = (state_q == S_ACCESS) ? wdata_q : '0;
    assign mem_len   = (state_q == S_ACCESS) ? len_q   : '0;

    assign ifu_resp_valid = (state_q == S_RESP) && (owner_q == OWN_IFU);
    assign lsu_resp_valid = (state_q == S_RESP) && (owner_q == OWN_LSU);
    assign ifu_rdata      = ifu_resp_valid ? resp_data_q : '0;
    assign lsu_rdata      = lsu_resp_valid ? resp_data_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed and randomized checks of mem_arbiter against a transaction-level
// reference: a grant-policy function, a behavioural memory (data is a pure
// function of the address) and expected latency/strobe rules.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam logic [1:0] LEN_B  = 2'b00;
    localparam logic [1:0] LEN_H  = 2'b01;
    localparam logic [1:0] LEN_UH = 2'b10;
    localparam logic [1:0] LEN_W  = 2'b11;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [1:0]  lsu_len;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_len;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_addr       (ifu_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_resp_ready (ifu_resp_ready),
        .ifu_rdata      (ifu_rdata),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_addr       (lsu_addr),
        .lsu_wen        (lsu_wen),
        .lsu_wdata      (lsu_wdata),
        .lsu_len        (lsu_len),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_resp_ready (lsu_resp_ready),
        .lsu_rdata      (lsu_rdata),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_len        (mem_len),
        .mem_rdata      (mem_rdata)
    );

    // ---------------- behavioural memory and strobe log ----------------
    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  len;
    } strobe_t;

    strobe_t strobe_q[$];
    int      both_strobes = 0;
    bit      prev_read    = 1'b0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    // Read data appears with the strobe and is held through the following
    // cycle only; otherwise the bus carries noise.
    always @(negedge clk) begin
        if (mem_read && mem_write) both_strobes++;
        if (mem_read || mem_write) strobe_q.push_back('{mem_write, mem_addr, mem_wdata, mem_len});
        if (mem_read)       mem_rdata = mem_fn(mem_addr);
        else if (!prev_read) mem_rdata = $urandom();
        prev_read = mem_read;
    end

    // ---------------- grant-policy reference ----------------
    bit last_lsu_won = 1'b0;   // last winner; IFU after reset

    function automatic bit model_pick_lsu(input bit iv, input bit lv);
        if (!lv) return 1'b0;
        if (!iv) return 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        return !last_lsu_won;
`else
        return 1'b1;
`endif
    endfunction

    // ---------------- transaction driver ----------------
    typedef struct {
        bit          timeout;
        bit          grant_lsu;
        bit          both_ready;
        int          latency;
        logic [31:0] rdata;
        int          n_strobe;
        strobe_t     st;
        bit          other_valid;
        bit          unstable;
        bit          ready_in_resp;
        bit          valid_after;
    } obs_t;

    task automatic do_txn(input bit iv, input bit lv, input logic [31:0] ia,
                          input logic [31:0] la, input bit lw, input logic [31:0] ld,
                          input logic [1:0] ll, input int hold, output obs_t o);
        int n;
        bit got;
        o.timeout = 0; o.grant_lsu = 0; o.both_ready = 0; o.latency = 0; o.rdata = '0;
        o.n_strobe = 0; o.st = '{1'b0, 32'h0, 32'h0, 2'b00}; o.other_valid = 0;
        o.unstable = 0; o.ready_in_resp = 0; o.valid_after = 0;

        @(posedge clk); #1;
        strobe_q.delete();
        ifu_req_valid = iv; ifu_addr = ia;
        lsu_req_valid = lv; lsu_addr = la; lsu_wen = lw; lsu_wdata = ld; lsu_len = ll;
        ifu_resp_ready = 0; lsu_resp_ready = 0;

        got = 0; n = 0;
        while (!got && n < 20) begin
            @(negedge clk); n++;
            if (ifu_req_ready || lsu_req_ready) begin
                got = 1;
                o.grant_lsu  = lsu_req_ready;
                o.both_ready = ifu_req_ready && lsu_req_ready;
            end
        end
        if (!got) begin
            o.timeout = 1; ifu_req_valid = 0; lsu_req_valid = 0;
            return;
        end

        @(posedge clk); #1;   // request handshake edge (cycle T ends)
        ifu_req_valid = 0; lsu_req_valid = 0;
        if (hold == 0) begin  // ready already high when RESP is entered
            ifu_resp_ready = !o.grant_lsu;
            lsu_resp_ready =  o.grant_lsu;
        end

        got = 0; n = 0;
        while (!got && n < 20) begin
            @(negedge clk); n++;
            if (o.grant_lsu ? lsu_resp_valid : ifu_resp_valid) got = 1;
            if (o.grant_lsu ? ifu_resp_valid : lsu_resp_valid) o.other_valid = 1;
        end
        if (!got) begin
            o.timeout = 1; ifu_resp_ready = 0; lsu_resp_ready = 0;
            return;
        end
        o.latency = n;
        o.rdata   = o.grant_lsu ? lsu_rdata : ifu_rdata;

        // While stalled, both requesters knock; neither may be granted.
        if (hold > 0) begin
            ifu_req_valid = 1; lsu_req_valid = 1;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!(o.grant_lsu ? lsu_resp_valid : ifu_resp_valid) ||
                ((o.grant_lsu ? lsu_rdata : ifu_rdata) !== o.rdata)) o.unstable = 1;
            if (ifu_req_ready || lsu_req_ready) o.ready_in_resp = 1;
            if (o.grant_lsu ? ifu_resp_valid : lsu_resp_valid) o.other_valid = 1;
        end
        ifu_req_valid = 0; lsu_req_valid = 0;
        ifu_resp_ready = !o.grant_lsu;
        lsu_resp_ready =  o.grant_lsu;
        @(posedge clk); #1;
        ifu_resp_ready = 0; lsu_resp_ready = 0;
        @(negedge clk);
        o.valid_after = ifu_resp_valid || lsu_resp_valid;
        o.n_strobe    = strobe_q.size();
        if (o.n_strobe > 0) o.st = strobe_q[0];
    endtask

    task automatic apply_reset;
        ifu_req_valid = 0; lsu_req_valid = 0; ifu_resp_ready = 0; lsu_resp_ready = 0;
        @(negedge clk); rst_n = 0;
        repeat (3) @(negedge clk);
        rst_n = 1; last_lsu_won = 0;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        ifu_req_valid = 1; ifu_addr = 32'h1234_5678; ifu_resp_ready = 1;
        lsu_req_valid = 1; lsu_addr = 32'h8765_4321; lsu_wen = 1; lsu_wdata = 32'hffff_ffff;
        lsu_len = LEN_W; lsu_resp_ready = 1;
        #1 rst_n = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_read, mem_write} !== 6'b0)
            begin errors++; $display("FAIL reset_ctrl: got %b required 000000",
                {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_read, mem_write}); end
        checks++;
        if ({mem_addr, mem_wdata, mem_len, ifu_rdata, lsu_rdata} !== '0)
            begin errors++; $display("FAIL reset_data: addr %h wdata %h len %b ifu %h lsu %h required all 0",
                mem_addr, mem_wdata, mem_len, ifu_rdata, lsu_rdata); end
        ifu_req_valid = 0; lsu_req_valid = 0; ifu_resp_ready = 0; lsu_resp_ready = 0;
        rst_n = 1; last_lsu_won = 0;
        @(negedge clk);
    endtask

    task automatic test_ifu_read;
        obs_t o;
        do_txn(1, 0, 32'h8000_0000, 32'h0, 0, 32'h0, LEN_W, 0, o);
        last_lsu_won = 0;
        checks++;
        if (o.timeout || o.grant_lsu) begin errors++;
            $display("FAIL ifu_grant: timeout %0d lsu %0d required ifu", o.timeout, o.grant_lsu); end
        checks++;
        if (o.latency !== 3) begin errors++; $display("FAIL ifu_latency: got %0d required 3", o.latency); end
        checks++;
        if (o.rdata !== 32'h0000_0413) begin errors++;
            $display("FAIL ifu_rdata: got %h required 00000413", o.rdata); end
        checks++;
        if ({o.n_strobe[3:0], o.st.write, o.st.addr, o.st.len} !== {4'd1, 1'b0, 32'h8000_0000, LEN_W})
            begin errors++; $display("FAIL ifu_strobe: n %0d write %0d addr %h len %b required 1 0 80000000 11",
                o.n_strobe, o.st.write, o.st.addr, o.st.len); end
        checks++;
        if (o.valid_after || o.other_valid) begin errors++;
            $display("FAIL ifu_resp_end: after %0d other %0d required 0 0", o.valid_after, o.other_valid); end
    endtask

    task automatic test_lsu_store;
        obs_t o;
        do_txn(0, 1, 32'h0, 32'h8000_1003, 1, 32'h0000_00ab, LEN_B, 1, o);
        last_lsu_won = 1;
        checks++;
        if (o.timeout || !o.grant_lsu) begin errors++;
            $display("FAIL sb_grant: timeout %0d lsu %0d required lsu", o.timeout, o.grant_lsu); end
        checks++;
        if ({o.n_strobe[3:0], o.st.write, o.st.addr, o.st.wdata, o.st.len} !==
            {4'd1, 1'b1, 32'h8000_1003, 32'h0000_00ab, LEN_B})
            begin errors++; $display("FAIL sb_strobe: n %0d write %0d addr %h wdata %h len %b required 1 1 80001003 000000ab 00",
                o.n_strobe, o.st.write, o.st.addr, o.st.wdata, o.st.len); end
        checks++;
        if (o.rdata !== 32'h0 || o.latency !== 3) begin errors++;
            $display("FAIL sb_resp: rdata %h latency %0d required 0 3", o.rdata, o.latency); end
    endtask

    task automatic test_uhalf;
        obs_t o;
        do_txn(0, 1, 32'h0, 32'h8000_2002, 1, 32'h0000_beef, LEN_UH, 0, o);
        last_lsu_won = 1;
        checks++;
        if (o.timeout || !o.st.write || o.st.len !== LEN_H) begin errors++;
            $display("FAIL uhalf_store_len: timeout %0d write %0d len %b required 0 1 01", o.timeout, o.st.write, o.st.len); end
        do_txn(0, 1, 32'h0, 32'h8000_2006, 0, 32'h0, LEN_UH, 0, o);
        checks++;
        if (o.timeout || o.st.write || o.st.len !== LEN_UH || o.rdata !== mem_fn(32'h8000_2006)) begin errors++;
            $display("FAIL uhalf_load: write %0d len %b rdata %h required 0 10 %h",
                o.st.write, o.st.len, o.rdata, mem_fn(32'h8000_2006)); end
    endtask

    task automatic test_stall;
        obs_t o;
        do_txn(1, 0, 32'h8000_0010, 32'h0, 0, 32'h0, LEN_W, 5, o);
        last_lsu_won = 0;
        checks++;
        if (o.timeout || o.rdata !== mem_fn(32'h8000_0010)) begin errors++;
            $display("FAIL stall_rdata: got %h required %h", o.rdata, mem_fn(32'h8000_0010)); end
        checks++;
        if ({o.unstable, o.ready_in_resp, o.other_valid, o.valid_after} !== 4'b0) begin errors++;
            $display("FAIL stall_hold: unstable %0d grant %0d other %0d after %0d required all 0",
                o.unstable, o.ready_in_resp, o.other_valid, o.valid_after); end
        checks++;
        if (o.n_strobe !== 1) begin errors++; $display("FAIL stall_strobes: got %0d required 1", o.n_strobe); end
    endtask

    task automatic test_back_to_back;
        bit exp_lsu;
        int grants = 0, cyc = 0, last_cyc = 0;
        apply_reset();
        @(posedge clk); #1;
        strobe_q.delete();
        ifu_req_valid = 1; ifu_addr = 32'h8000_0100;
        lsu_req_valid = 1; lsu_addr = 32'h8000_0200; lsu_wen = 0; lsu_len = LEN_W;
        ifu_resp_ready = 1; lsu_resp_ready = 1;
        while (grants < 4 && cyc < 80) begin
            @(negedge clk); cyc++;
            if (ifu_req_ready || lsu_req_ready) begin
                exp_lsu = model_pick_lsu(1, 1);
                last_lsu_won = exp_lsu;
                checks++;
                if ({ifu_req_ready, lsu_req_ready} !== {!exp_lsu, exp_lsu}) begin errors++;
                    $display("FAIL tie_grant%0d: ifu %0d lsu %0d required ifu %0d lsu %0d",
                        grants, ifu_req_ready, lsu_req_ready, !exp_lsu, exp_lsu); end
                if (grants > 0) begin
                    checks++;
                    if (cyc - last_cyc != 4) begin errors++;
                        $display("FAIL b2b_gap%0d: got %0d cycles required 4", grants, cyc - last_cyc); end
                end
                last_cyc = cyc;
                grants++;
                if (grants == 4) begin
                    @(posedge clk); #1;
                    ifu_req_valid = 0; lsu_req_valid = 0;
                end
            end
        end
        checks++;
        if (grants != 4) begin errors++; $display("FAIL tie_timeout: got %0d grants required 4", grants); end
        repeat (6) @(negedge clk);
        ifu_resp_ready = 0; lsu_resp_ready = 0;
        checks++;
        if (strobe_q.size() != 4) begin errors++;
            $display("FAIL b2b_strobes: got %0d required 4", strobe_q.size()); end
    endtask

    task automatic test_reset_mid;
        obs_t o;
        int n;
        for (int stage = 0; stage < 2; stage++) begin
            @(posedge clk); #1;
            lsu_req_valid = 1; lsu_addr = 32'h8000_0040; lsu_wen = (stage == 0);
            lsu_wdata = 32'hdead_beef; lsu_len = LEN_W; lsu_resp_ready = 0;
            n = 0;
            while (!lsu_req_ready && n < 20) begin @(negedge clk); n++; end
            @(posedge clk); #1;                       // now in ACCESS
            ifu_req_valid = 1;                        // ignored outside IDLE
            if (stage == 1) begin repeat (2) @(posedge clk); #1; end   // now in RESP
            checks++;
            if ((stage == 0 ? mem_write : lsu_resp_valid) !== 1'b1) begin errors++;
                $display("FAIL rst_mid%0d_pre: state output got %0d required 1", stage,
                    stage == 0 ? mem_write : lsu_resp_valid); end
            #1 rst_n = 0;
            #1;
            checks++;
            if ({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_read, mem_write,
                 mem_addr, mem_wdata, mem_len, ifu_rdata, lsu_rdata} !== '0) begin errors++;
                $display("FAIL rst_mid%0d_async: ctrl %b addr %h wdata %h rdata %h required all 0", stage,
                    {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_read, mem_write},
                    mem_addr, mem_wdata, lsu_rdata); end
            strobe_q.delete();
            repeat (3) @(negedge clk);
            ifu_req_valid = 0; lsu_req_valid = 0;
            rst_n = 1; last_lsu_won = 0;
            repeat (4) @(negedge clk);
            checks++;
            if (strobe_q.size() != 0 || lsu_resp_valid || ifu_resp_valid) begin errors++;
                $display("FAIL rst_mid%0d_quiet: strobes %0d resp %0d required 0 0", stage,
                    strobe_q.size(), lsu_resp_valid | ifu_resp_valid); end
            do_txn(1, 0, 32'h8000_0000, 32'h0, 0, 32'h0, LEN_W, 0, o);
            last_lsu_won = 0;
            checks++;
            if (o.timeout || o.grant_lsu || o.latency !== 3 || o.rdata !== 32'h0000_0413) begin errors++;
                $display("FAIL rst_mid%0d_after: timeout %0d lsu %0d latency %0d rdata %h required 0 0 3 00000413",
                    stage, o.timeout, o.grant_lsu, o.latency, o.rdata); end
        end
    endtask

    task automatic test_random;
        obs_t        o;
        int          kind, hold;
        bit          iv, lv, lw, exp_lsu, exp_w;
        logic [31:0] ia, la, ld, exp_a, exp_rd;
        logic [1:0]  ll, exp_len;
        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 2);
            iv = (kind != 1); lv = (kind != 0);
            ia = $urandom(); la = $urandom(); ld = $urandom();
            lw = 1'($urandom_range(0, 1)); ll = 2'($urandom_range(0, 3));
            hold = $urandom_range(0, 3);
            exp_lsu = model_pick_lsu(iv, lv);
            last_lsu_won = exp_lsu;
            exp_w   = exp_lsu && lw;
            exp_a   = exp_lsu ? la : ia;
            exp_len = !exp_lsu ? LEN_W : ((lw && ll == LEN_UH) ? LEN_H : ll);
            exp_rd  = exp_w ? 32'h0 : mem_fn(exp_a);
            do_txn(iv, lv, ia, la, lw, ld, ll, hold, o);
            checks++;
            if (o.timeout) begin errors++; $display("FAIL rnd%0d_timeout: no grant or response", i); end
            else begin
                checks++;
                if ({o.grant_lsu, o.both_ready, o.latency[3:0], o.n_strobe[3:0]} !== {exp_lsu, 1'b0, 4'd3, 4'd1})
                    begin errors++; $display("FAIL rnd%0d_flow: lsu %0d both %0d lat %0d strobes %0d required %0d 0 3 1",
                        i, o.grant_lsu, o.both_ready, o.latency, o.n_strobe, exp_lsu); end
                checks++;
                if ({o.st.write, o.st.addr, o.st.len} !== {exp_w, exp_a, exp_len} ||
                    (exp_w && o.st.wdata !== ld)) begin errors++;
                    $display("FAIL rnd%0d_strobe: w %0d addr %h len %b wdata %h required %0d %h %b %h",
                        i, o.st.write, o.st.addr, o.st.len, o.st.wdata, exp_w, exp_a, exp_len, ld); end
                checks++;
                if (o.rdata !== exp_rd) begin errors++;
                    $display("FAIL rnd%0d_rdata: got %h required %h", i, o.rdata, exp_rd); end
                checks++;
                if ({o.unstable, o.ready_in_resp, o.other_valid, o.valid_after} !== 4'b0) begin errors++;
                    $display("FAIL rnd%0d_resp: unstable %0d grant %0d other %0d after %0d required all 0",
                        i, o.unstable, o.ready_in_resp, o.other_valid, o.valid_after); end
            end
        end
    endtask

    task automatic test_invariants;
        checks++;
        if (both_strobes != 0) begin errors++;
            $display("FAIL strobe_exclusive: read+write together in %0d cycles required 0", both_strobes); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ifu_read();
        test_lsu_store();
        test_uhalf();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_invariants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
